// File: rtl/rib_uart_pkg.sv
// Shared definitions for the RIB UART: bus widths, register offsets, STATUS bits, FSM encodings.
package rib_uart_pkg;

    localparam int unsigned AddrBus = 32;
    localparam int unsigned DataBus = 32;
    localparam logic [DataBus-1:0] ZeroWord = 32'h0;
    localparam logic WriteEnable = 1'b1;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_BAUD   = 8'h08;
    localparam logic [7:0] REG_TXDATA = 8'h0C;
    localparam logic [7:0] REG_RXDATA = 8'h10;

    localparam int unsigned ST_TX_BUSY    = 0;
    localparam int unsigned ST_FIFO_FULL  = 1;
    localparam int unsigned ST_FIFO_EMPTY = 2;
    localparam int unsigned ST_RX_VALID   = 3;
    localparam int unsigned ST_RX_OVERRUN = 4;
    localparam int unsigned ST_TX_DROP    = 5;
    localparam int unsigned ST_RX_FERR    = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Divisors below 2 cannot form a bit time; clamp them.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/rib_uart_fifo.sv
// Synchronous TX FIFO; pointers carry one extra wrap bit to tell full from empty.
module rib_uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/rib_uart.sv
// Memory-mapped UART on a RIB slave port with a TX FIFO.
// Define RIB_UART_RX_EN to build the rx port and receiver.
module rib_uart
    import rib_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AddrBus-1:0] wraddr,
    input  logic [DataBus-1:0] wdata,
    input  logic               we,
    output logic [DataBus-1:0] rdata,
`ifdef RIB_UART_RX_EN
    input  logic               rx,
`endif
    output logic               tx
);
`ifdef RIB_UART_RX_EN
    localparam logic RxBuilt = 1'b1;
`else
    localparam logic RxBuilt = 1'b0;
`endif

    logic [7:0]  addr;
    logic        wr_ctrl, wr_status, wr_baud, wr_txdata, wr_rxdata;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d, div_eff;
    logic        tx_drop_q, tx_drop_d;
    tx_state_e   state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, fifo_rdata, rx_byte;
    logic        tx_q, tx_d, bit_end, pop_c, fifo_full, fifo_empty;
    logic        rx_valid, rx_overrun, rx_frame_err;
    logic [DataBus-1:0] status_c;
    logic        unused_bits;

    assign unused_bits = ^{wraddr[AddrBus-1:8], wdata[DataBus-1:16]};
    assign addr      = wraddr[7:0];
    assign wr_ctrl   = (we == WriteEnable) && (addr == REG_CTRL);
    assign wr_status = (we == WriteEnable) && (addr == REG_STATUS);
    assign wr_baud   = (we == WriteEnable) && (addr == REG_BAUD);
    assign wr_txdata = (we == WriteEnable) && (addr == REG_TXDATA);
    assign wr_rxdata = (we == WriteEnable) && (addr == REG_RXDATA);
    assign div_eff   = eff_div(baud_q);
    assign bit_end   = baud_cnt_q >= (div_eff - 16'd1);
    assign tx        = tx_q;

    rib_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_txdata),
        .wdata_i (wdata[7:0]),
        .pop_i   (pop_c),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            baud_q     <= DEFAULT_DIV;
            tx_drop_q  <= 1'b0;
            state_q    <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            tx_drop_q  <= tx_drop_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // Register writes and TX framing; the baud compare is live so BAUD edits take effect mid-bit.
    always_comb begin
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        tx_drop_d  = tx_drop_q;
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop_c      = 1'b0;

        if (wr_ctrl) ctrl_d = {wdata[1] & RxBuilt, wdata[0]};
        if (wr_baud) baud_d = wdata[15:0];
        if (wr_status && wdata[ST_TX_DROP]) tx_drop_d = 1'b0;
        if (wr_txdata && fifo_full) tx_drop_d = 1'b1;

        case (state_q)
            TX_IDLE: begin
                baud_cnt_d = '0;
                if (ctrl_q[0] && !fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_rdata;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (ctrl_q[0] && !fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_rdata;
                        tx_d    = 1'b0;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

`ifdef RIB_UART_RX_EN
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q, rx_s;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, rx_ferr_q, rx_ferr_d;

    assign rx_s         = rx_sync_q[1];
    assign rx_byte      = rx_byte_q;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = rx_overrun_q;
    assign rx_frame_err = rx_ferr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q    <= 2'b11;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            rx_sync_q    <= {rx_sync_q[0], rx};
            rx_prev_q    <= rx_s;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            rx_ferr_q    <= rx_ferr_d;
        end
    end

    // Receiver: half-bit start qualification, then one sample per bit time; set beats clear.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + 16'd1;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        rx_ferr_d    = rx_ferr_q;

        if (wr_rxdata) rx_valid_d = 1'b0;
        if (wr_status && wdata[ST_RX_OVERRUN]) rx_overrun_d = 1'b0;
        if (wr_status && wdata[ST_RX_FERR]) rx_ferr_d = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q >= ((div_eff >> 1) - 16'd1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q >= (div_eff - 16'd1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q >= (div_eff - 16'd1)) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (!rx_s) begin
                        rx_ferr_d = 1'b1;
                    end else if (ctrl_q[1]) begin
                        rx_byte_d    = rx_shift_q;
                        rx_valid_d   = 1'b1;
                        rx_overrun_d = rx_overrun_d | rx_valid_q;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end
`else
    assign rx_byte      = 8'h00;
    assign rx_valid     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
`endif

    always_comb begin
        status_c                = ZeroWord;
        status_c[ST_TX_BUSY]    = (state_q != TX_IDLE);
        status_c[ST_FIFO_FULL]  = fifo_full;
        status_c[ST_FIFO_EMPTY] = fifo_empty;
        status_c[ST_RX_VALID]   = rx_valid;
        status_c[ST_RX_OVERRUN] = rx_overrun;
        status_c[ST_TX_DROP]    = tx_drop_q;
        status_c[ST_RX_FERR]    = rx_frame_err;
    end

    always_comb begin
        rdata = ZeroWord;
        case (addr)
            REG_CTRL:   rdata[1:0]  = ctrl_q;
            REG_STATUS: rdata       = status_c;
            REG_BAUD:   rdata[15:0] = baud_q;
            REG_RXDATA: rdata[7:0]  = rx_byte;
            default:    rdata       = ZeroWord;
        endcase
    end

endmodule

// File: tb/tb_rib_uart.sv
// Directed self-checking bench for rib_uart; RX scenarios build only with RIB_UART_RX_EN.
module tb_rib_uart;

    logic        clk;
    logic        rst;
    logic [31:0] wraddr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        tx;
`ifdef RIB_UART_RX_EN
    logic        rx;
`endif
    int total;
    int bad;

    rib_uart #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd434)) dut (
        .clk    (clk),
        .rst    (rst),
        .wraddr (wraddr),
        .wdata  (wdata),
        .we     (we),
        .rdata  (rdata),
`ifdef RIB_UART_RX_EN
        .rx     (rx),
`endif
        .tx     (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write strobe straddling a rising edge; leaves STATUS on the address bus.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wraddr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; wraddr = 32'h4; wdata = 32'h0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        wraddr = a;
        #1;
        d = rdata;
        wraddr = 32'h4;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; we = 1'b0; wraddr = 32'h4; wdata = 32'h0;
`ifdef RIB_UART_RX_EN
        rx = 1'b1;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_rd(32'h04, d); total++;
        if (d !== 32'h4) begin bad++; $display("FAIL reset_status: got %h expected %h", d, 32'h4); end
        bus_rd(32'h08, d); total++;
        if (d !== 32'd434) begin bad++; $display("FAIL reset_baud: got %h expected %h", d, 32'd434); end
        bus_rd(32'h00, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        bus_wr(32'h00, 32'h3);
        bus_rd(32'h00, d); total++;
`ifdef RIB_UART_RX_EN
        if (d !== 32'h3) begin bad++; $display("FAIL ctrl_rw: got %h expected %h", d, 32'h3); end
`else
        if (d !== 32'h1) begin bad++; $display("FAIL ctrl_rw: got %h expected %h", d, 32'h1); end
`endif
        bus_wr(32'h14, 32'hFFFF_FFFF);
        bus_rd(32'h14, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd: got %h expected 0", d); end
        bus_rd(32'h0C, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL txdata_rd: got %h expected 0", d); end
        bus_rd(32'h10, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rxdata_rd: got %h expected 0", d); end
        bus_wr(32'h00, 32'h0);
        bus_rd(32'h04, d); total++;
        if (d !== 32'h4) begin bad++; $display("FAIL regs_status: got %h expected %h", d, 32'h4); end
    endtask

    task automatic test_tx_frame();
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        bus_wr(32'h08, 32'd4);
        bus_wr(32'h00, 32'h1);
        bus_wr(32'h0C, 32'hA5);
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL tx_before_e1: got %b expected 1", tx); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            total++;
            if (tx !== fr[k/4]) begin bad++; $display("FAIL a5_tx[%0d]: got %b expected %b", k, tx, fr[k/4]); end
            total++;
            if (rdata[0] !== 1'b1) begin bad++; $display("FAIL a5_busy[%0d]: got %b expected 1", k, rdata[0]); end
        end
        @(negedge clk);
        total++;
        if (rdata !== 32'h4) begin bad++; $display("FAIL a5_done_status: got %h expected %h", rdata, 32'h4); end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL a5_done_tx: got %b expected 1", tx); end
    endtask

    task automatic test_baud_min();
        logic [31:0] d;
        logic [9:0]  fr;
        fr = {1'b1, 8'h0F, 1'b0};
        bus_wr(32'h08, 32'd0);
        bus_rd(32'h08, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL baud0_rd: got %h expected 0", d); end
        bus_wr(32'h00, 32'h1);
        bus_wr(32'h0C, 32'h0F);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++;
            if (tx !== fr[k/2]) begin bad++; $display("FAIL baud0_tx[%0d]: got %b expected %b", k, tx, fr[k/2]); end
        end
        @(negedge clk);
        total++;
        if (rdata !== 32'h4) begin bad++; $display("FAIL baud0_done: got %h expected %h", rdata, 32'h4); end
        bus_wr(32'h00, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  bytes [5];
        logic [9:0]  fr;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
        bus_wr(32'h08, 32'd4);
        bus_wr(32'h00, 32'h0);
        for (int i = 0; i < 5; i++) bus_wr(32'h0C, {24'h0, bytes[i]});
        bus_rd(32'h04, d); total++;
        if (d !== 32'h22) begin bad++; $display("FAIL full_drop_status: got %h expected %h", d, 32'h22); end
        bus_wr(32'h04, 32'h20);
        bus_rd(32'h04, d); total++;
        if (d !== 32'h02) begin bad++; $display("FAIL drop_w1c: got %h expected %h", d, 32'h02); end
        bus_wr(32'h00, 32'h1);
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            fr = {1'b1, bytes[k/40], 1'b0};
            total++;
            if (tx !== fr[(k%40)/4]) begin bad++; $display("FAIL b2b_tx[%0d]: got %b expected %b", k, tx, fr[(k%40)/4]); end
            total++;
            if (rdata[0] !== 1'b1) begin bad++; $display("FAIL b2b_busy[%0d]: got %b expected 1", k, rdata[0]); end
        end
        @(negedge clk);
        total++;
        if (rdata !== 32'h4) begin bad++; $display("FAIL b2b_done: got %h expected %h", rdata, 32'h4); end
    endtask

    task automatic test_txen_clear();
        logic [31:0] d;
        int busy_cnt;
        bus_wr(32'h00, 32'h0);
        bus_wr(32'h0C, 32'h81);
        bus_wr(32'h0C, 32'h42);
        bus_wr(32'h0C, 32'h24);
        bus_wr(32'h00, 32'h1);
        busy_cnt = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            we = 1'b0; wraddr = 32'h4;
            #1;
            if (rdata[0] === 1'b1) busy_cnt++;
            if (k == 12) begin wraddr = 32'h0; wdata = 32'h0; we = 1'b1; end
        end
        total++;
        if (busy_cnt !== 40) begin bad++; $display("FAIL txen_busy_cycles: got %0d expected 40", busy_cnt); end
        bus_rd(32'h04, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL txen_status: got %h expected 0", d); end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL txen_tx: got %b expected 1", tx); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_wr(32'h00, 32'h1);
        repeat (6) @(negedge clk);
        total++;
        if (tx !== 1'b0) begin bad++; $display("FAIL mid_data_bit0: got %b expected 0", tx); end
        #1 rst = 1'b1;
        #1;
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL async_rst_tx: got %b expected 1", tx); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_rd(32'h04, d); total++;
        if (d !== 32'h4) begin bad++; $display("FAIL rst_mid_status: got %h expected %h", d, 32'h4); end
        bus_rd(32'h08, d); total++;
        if (d !== 32'd434) begin bad++; $display("FAIL rst_mid_baud: got %h expected %h", d, 32'd434); end
        bus_wr(32'h08, 32'd4);
        bus_wr(32'h00, 32'h1);
        repeat (20) @(negedge clk);
        bus_rd(32'h04, d); total++;
        if (d !== 32'h4) begin bad++; $display("FAIL fifo_flushed: got %h expected %h", d, 32'h4); end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL flushed_tx: got %b expected 1", tx); end
        bus_wr(32'h00, 32'h0);
    endtask

`ifdef RIB_UART_RX_EN
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (8) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_rx();
        logic [31:0] d;
        bus_wr(32'h08, 32'd8);
        bus_wr(32'h00, 32'h2);
        send_rx(8'h3C, 1'b1);
        bus_rd(32'h10, d); total++;
        if (d !== 32'h3C) begin bad++; $display("FAIL rx_byte1: got %h expected %h", d, 32'h3C); end
        bus_rd(32'h04, d); total++;
        if (d !== 32'h0C) begin bad++; $display("FAIL rx_valid1: got %h expected %h", d, 32'h0C); end
        send_rx(8'h55, 1'b1);
        bus_rd(32'h10, d); total++;
        if (d !== 32'h55) begin bad++; $display("FAIL rx_byte2: got %h expected %h", d, 32'h55); end
        bus_rd(32'h04, d); total++;
        if (d !== 32'h1C) begin bad++; $display("FAIL rx_overrun: got %h expected %h", d, 32'h1C); end
        bus_wr(32'h10, 32'h0);
        bus_wr(32'h04, 32'h10);
        bus_rd(32'h04, d); total++;
        if (d !== 32'h04) begin bad++; $display("FAIL rx_clear: got %h expected %h", d, 32'h04); end
        send_rx(8'hA0, 1'b0);
        bus_rd(32'h04, d); total++;
        if (d !== 32'h44) begin bad++; $display("FAIL rx_frame_err: got %h expected %h", d, 32'h44); end
        bus_rd(32'h10, d); total++;
        if (d !== 32'h55) begin bad++; $display("FAIL rx_byte_kept: got %h expected %h", d, 32'h55); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_regs();
        test_tx_frame();
        test_baud_min();
        test_back_to_back();
        test_txen_clear();
        test_reset_mid();
`ifdef RIB_UART_RX_EN
        test_rx();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
